// File: rtl/bitcoin_nonce_select_pkg.sv
// Shared definitions for the nonce-select stage of the bitcoin hash core.
// Holds the FSM state encoding, default scan length, result-record layout
// and a helper that packs the first result word.
package bitcoin_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE0 = 2'd2,
    WRITE1 = 2'd3
  } state_t;

  localparam int NUM_OF_NONCES_DEF = 16;
  localparam int RESULT_WORDS      = 2;

  // Result word 0 layout: found flag in the MSB, nonce index in the low byte.
  localparam int FOUND_BIT = 31;
  localparam int IDX_LSB   = 0;
  localparam int IDX_W     = 8;

  function automatic logic [31:0] pack_result_word(input logic found,
                                                   input logic [IDX_W-1:0] idx);
    logic [31:0] w;
    w = '0;
    w[FOUND_BIT] = found;
    w[IDX_LSB +: IDX_W] = idx;
    return w;
  endfunction

endpackage

// File: rtl/bitcoin_nonce_select_if.sv
// Memory bus shared with the hash core: single clock, synchronous write,
// read data returned the cycle after the address is presented.
// Ports (signals):
//   mem_clk        memory clock, driven by the master
//   mem_we         write enable
//   mem_addr       word address
//   mem_write_data write data
//   mem_read_data  read data from the memory
interface bitcoin_nonce_select_if #(
  parameter int ADDR_W = 16
);

  logic              mem_clk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  modport master (
    output mem_clk,
    output mem_we,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/bitcoin_nonce_select_nonce_cmp_track.sv
// Registered tracker for one scan: remembers the first nonce whose H0 is
// strictly below the target, and the smallest H0 seen so far.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             start of a new scan: reset the tracked results
//   vld             h0/idx carry a fresh word this cycle
//   idx, h0, target candidate nonce index, its H0 and the pass threshold
//   found, nonce_idx, min_hash     registered results
//   found_nxt, nonce_idx_nxt       values the registers take at the next edge
module nonce_cmp_track
  import bitcoin_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             vld,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      h0,
  input  logic [31:0]      target,
  output logic             found,
  output logic [IDX_W-1:0] nonce_idx,
  output logic [31:0]      min_hash,
  output logic             found_nxt,
  output logic [IDX_W-1:0] nonce_idx_nxt
);

  logic             r_found;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_min;
  logic [31:0]      w_min_nxt;

  // Only the first passing nonce is recorded; strict compare on the minimum
  // keeps the earlier word on ties.
  always_comb begin
    found_nxt     = r_found;
    nonce_idx_nxt = r_idx;
    w_min_nxt     = r_min;
    if (clr) begin
      found_nxt     = 1'b0;
      nonce_idx_nxt = '0;
      w_min_nxt     = 32'hFFFF_FFFF;
    end else if (vld) begin
      if (!r_found && (h0 < target)) begin
        found_nxt     = 1'b1;
        nonce_idx_nxt = idx;
      end
      if (h0 < r_min) begin
        w_min_nxt = h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_found <= 1'b0;
      r_idx   <= '0;
      r_min   <= 32'hFFFF_FFFF;
    end else begin
      r_found <= found_nxt;
      r_idx   <= nonce_idx_nxt;
      r_min   <= w_min_nxt;
    end
  end

  assign found     = r_found;
  assign nonce_idx = r_idx;
  assign min_hash  = r_min;

endmodule

// File: rtl/bitcoin_nonce_select.sv
// Nonce selection stage: scans NUM_OF_NONCES H0 words from memory, reports
// the lowest nonce whose H0 is below the target plus the minimum H0, and
// writes a two-word result record {found/idx, min_hash} back to memory.
// Ports:
//   clk, reset_n    clock, async active-low reset
//   start           begin a scan (sampled in IDLE only)
//   hash_addr       address of nonce 0's H0 word
//   result_addr     address of the 2-word result record
//   target          pass threshold (H0 < target)
//   done            high while idle
//   found, nonce_idx, min_hash  results of the last scan
//   mem             memory bus master
module bitcoin_nonce_select
  import bitcoin_pkg::*;
#(
  parameter int NUM_OF_NONCES = NUM_OF_NONCES_DEF,
  parameter int ADDR_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       hash_addr,
  input  logic [ADDR_W-1:0]       result_addr,
  input  logic [31:0]             target,
  output logic                    done,
  output logic                    found,
  output logic [IDX_W-1:0]        nonce_idx,
  output logic [31:0]             min_hash,
  bitcoin_nonce_select_if.master  mem
);

  // Read counter spans 0..NUM_OF_NONCES (one extra cycle to catch the last word).
  localparam int             KW  = 9;
  localparam logic [KW-1:0]  N_K = KW'(NUM_OF_NONCES);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_clr;
  logic              w_vld;
  logic [KW-1:0]     r_k;
  logic [KW-1:0]     w_k_inc;
  logic [ADDR_W-1:0] r_hash_addr;
  logic [ADDR_W-1:0] r_result_addr;
  logic [31:0]       r_target;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              w_found_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [IDX_W-1:0]  w_cap_idx;

  assign w_k_inc   = r_k + 9'd1;
  // Word arriving in cycle k belongs to nonce k-1.
  assign w_cap_idx = IDX_W'(r_k - 9'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_vld        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = READ;
          w_clr        = 1'b1;
        end
      end
      READ: begin
        w_vld = (r_k != '0);
        if (r_k == N_K) begin
          w_next_state = WRITE0;
        end
      end
      WRITE0:  w_next_state = WRITE1;
      WRITE1:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Bus outputs are registered, so each cycle's address/data is loaded at
  // the edge that enters that cycle. Word 0 of the record therefore uses the
  // tracker's next values, since the last nonce is captured on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k           <= '0;
      r_hash_addr   <= '0;
      r_result_addr <= '0;
      r_target      <= '0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_mem_we <= 1'b0;
          if (start) begin
            r_hash_addr   <= hash_addr;
            r_result_addr <= result_addr;
            r_target      <= target;
            r_k           <= '0;
            r_mem_addr    <= hash_addr;
          end
        end
        READ: begin
          r_k <= w_k_inc;
          if (r_k == N_K) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_result_addr;
            r_mem_wdata <= pack_result_word(w_found_nxt, w_idx_nxt);
          end else if (w_k_inc < N_K) begin
            r_mem_addr <= r_hash_addr + ADDR_W'(w_k_inc);
          end
        end
        WRITE0: begin
          r_mem_addr  <= r_result_addr + ADDR_W'(1);
          r_mem_wdata <= min_hash;
        end
        WRITE1: begin
          r_mem_we <= 1'b0;
        end
        default: begin
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  nonce_cmp_track u_track (
    .clk           (clk),
    .rst_n         (reset_n),
    .clr           (w_clr),
    .vld           (w_vld),
    .idx           (w_cap_idx),
    .h0            (mem.mem_read_data),
    .target        (r_target),
    .found         (found),
    .nonce_idx     (nonce_idx),
    .min_hash      (min_hash),
    .found_nxt     (w_found_nxt),
    .nonce_idx_nxt (w_idx_nxt)
  );

  assign done               = (r_state == IDLE);
  assign mem.mem_clk        = clk;
  assign mem.mem_we         = r_mem_we;
  assign mem.mem_addr       = r_mem_addr;
  assign mem.mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_bitcoin_nonce_select.sv
// Bench for bitcoin_nonce_select: directed scans with hand-computed records,
// a memory model on the bus, and a monitor that checks read addresses and
// result records against a scoreboard queue.
module tb_bitcoin_nonce_select;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] hash_addr = '0;
  logic [15:0] result_addr = '0;
  logic [31:0] target = '0;
  logic        done;
  logic        found;
  logic [7:0]  nonce_idx;
  logic [31:0] min_hash;

  bitcoin_nonce_select_if #(.ADDR_W(16)) mif ();

  bitcoin_nonce_select #(.NUM_OF_NONCES(N), .ADDR_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .hash_addr   (hash_addr),
    .result_addr (result_addr),
    .target      (target),
    .done        (done),
    .found       (found),
    .nonce_idx   (nonce_idx),
    .min_hash    (min_hash),
    .mem         (mif.master)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous read, one-cycle latency; bench preload port.
  logic [31:0] memArr [0:65535];
  logic        ldEn = 1'b0;
  logic [15:0] ldAddr = '0;
  logic [31:0] ldData = '0;

  always @(posedge clk) begin
    if (ldEn) memArr[ldAddr] <= ldData;
    else if (mif.mem_we) memArr[mif.mem_addr] <= mif.mem_write_data;
    mif.mem_read_data <= memArr[mif.mem_addr];
  end

  typedef struct {
    logic [15:0] resAddr;
    logic [31:0] word0;
    logic [31:0] word1;
    logic        found;
    logic [7:0]  idx;
    logic [31:0] minH;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        monExp;
  logic [15:0] curBase = '0;
  int          cmpCount = 0;
  int          errCount = 0;
  logic [31:0] vec [16];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: read addresses during a scan, then the two-word record.
  int          rdCnt = 0;
  int          wrCnt = 0;
  logic [15:0] wAddr0;
  logic [31:0] wData0;

  always @(negedge clk) begin
    if (!reset_n || done) begin
      rdCnt = 0;
      wrCnt = 0;
    end else if (!mif.mem_we) begin
      if (rdCnt < N)
        checkOutput("readAddr", 32'(mif.mem_addr), 32'(16'(curBase + 16'(rdCnt))));
      rdCnt++;
    end else if (wrCnt == 0) begin
      wAddr0 = mif.mem_addr;
      wData0 = mif.mem_write_data;
      wrCnt  = 1;
    end else begin
      if (sbQ.size() == 0) begin
        cmpCount++;
        errCount++;
        $display("[TB] FAIL unexpectedRecord: got %h expected none", wData0);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("word0Addr", 32'(wAddr0), 32'(monExp.resAddr));
        checkOutput("word0", wData0, monExp.word0);
        checkOutput("word1Addr", 32'(mif.mem_addr), 32'(16'(monExp.resAddr + 16'd1)));
        checkOutput("word1", mif.mem_write_data, monExp.word1);
        checkOutput("found", 32'(found), 32'(monExp.found));
        checkOutput("nonceIdx", 32'(nonce_idx), 32'(monExp.idx));
        checkOutput("minHash", min_hash, monExp.minH);
      end
      wrCnt = 0;
    end
  end

  task automatic loadWord(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    ldEn   = 1'b1;
    ldAddr = addr;
    ldData = data;
    @(negedge clk);
    ldEn = 1'b0;
  endtask

  task automatic loadVec(input logic [15:0] base);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      ldEn   = 1'b1;
      ldAddr = 16'(base + 16'(i));
      ldData = vec[i];
    end
    @(negedge clk);
    ldEn = 1'b0;
  endtask

  // One full scan: push expected record, pulse start, time the busy window.
  task automatic applyStimulus(input logic [15:0] base, input logic [15:0] res,
                               input logic [31:0] tgt, input logic expFound,
                               input logic [7:0] expIdx, input logic [31:0] expMin,
                               input logic [31:0] expWord0, input logic midPulse);
    exp_t e;
    int   lowCnt;
    e.resAddr = res;
    e.word0   = expWord0;
    e.word1   = expMin;
    e.found   = expFound;
    e.idx     = expIdx;
    e.minH    = expMin;
    sbQ.push_back(e);
    curBase     = base;
    hash_addr   = base;
    result_addr = res;
    target      = tgt;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    hash_addr   = 16'h5555;
    result_addr = 16'h6666;
    target      = 32'hFFFF_FFFF;
    lowCnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) break;
      lowCnt++;
      start = (midPulse && lowCnt == 5);
    end
    start = 1'b0;
    checkOutput("doneLowCycles", 32'(lowCnt), 32'd19);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rstDone", 32'(done), 32'd1);
    checkOutput("rstWe", 32'(mif.mem_we), 32'd0);
    checkOutput("rstAddr", 32'(mif.mem_addr), 32'd0);
    checkOutput("rstWdata", mif.mem_write_data, 32'd0);
    checkOutput("rstFound", 32'(found), 32'd0);
    checkOutput("rstIdx", 32'(nonce_idx), 32'd0);
    checkOutput("rstMin", min_hash, 32'hFFFF_FFFF);
    reset_n = 1'b1;
    @(negedge clk);

    // Ascending words, nonce 0 passes first and is the minimum
    for (int i = 0; i < N; i++) vec[i] = 32'h1000_0000 + 32'(i);
    loadVec(16'h0100);
    applyStimulus(16'h0100, 16'h0200, 32'h1000_0005, 1'b1, 8'd0,
                  32'h1000_0000, 32'h8000_0000, 1'b0);
    checkOutput("memWord0", memArr[16'h0200], 32'h8000_0000);
    checkOutput("memWord1", memArr[16'h0201], 32'h1000_0000);

    // Single passing nonce at index 11
    for (int i = 0; i < N; i++) vec[i] = 32'hFFFF_0000;
    vec[11] = 32'h0000_0ABC;
    loadVec(16'h0300);
    applyStimulus(16'h0300, 16'h0210, 32'h0000_FFFF, 1'b1, 8'd11,
                  32'h0000_0ABC, 32'h8000_000B, 1'b0);

    // target 0: nothing passes, minimum still tracked
    vec = '{32'h5A5A_5A5A, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0BAD_F00D,
            32'h7FFF_FFFF, 32'h0010_0000, 32'hC0FF_EE00, 32'h0000_8000,
            32'h3141_5926, 32'h0000_7777, 32'h89AB_CDEF, 32'h0001_0000,
            32'hF0F0_F0F0, 32'h0000_7778, 32'h4000_0000, 32'h0000_FFFF};
    loadVec(16'h0500);
    applyStimulus(16'h0500, 16'h0230, 32'h0000_0000, 1'b0, 8'd0,
                  32'h0000_7777, 32'h0000_0000, 1'b0);

    // Duplicate minimum at 4 and 9, nonce 6 equals target
    for (int i = 0; i < N; i++) vec[i] = 32'hFFFF_FFFF;
    vec[4] = 32'h0000_0001;
    vec[9] = 32'h0000_0001;
    vec[6] = 32'h0000_0100;
    loadVec(16'h0600);
    applyStimulus(16'h0600, 16'h0240, 32'h0000_0100, 1'b1, 8'd4,
                  32'h0000_0001, 32'h8000_0004, 1'b0);

    // Only candidate equals target: strict compare fails
    for (int i = 0; i < N; i++) vec[i] = 32'hFFFF_FFFF;
    vec[2] = 32'h0000_0100;
    loadVec(16'h0700);
    applyStimulus(16'h0700, 16'h0250, 32'h0000_0100, 1'b0, 8'd0,
                  32'h0000_0100, 32'h0000_0000, 1'b0);

    // Address wrap, descending words, mid-scan start pulse ignored
    for (int i = 0; i < N; i++) vec[i] = 32'h3000_0000 - 32'(i * 16);
    loadVec(16'hFFF8);
    applyStimulus(16'hFFF8, 16'h0260, 32'h2FFF_FF50, 1'b1, 8'd12,
                  32'h2FFF_FF10, 32'h8000_000C, 1'b1);

    // Reset abort at read k=7: no record written
    for (int i = 0; i < N; i++) vec[i] = 32'hFFFF_0000;
    vec[11] = 32'h0000_0ABC;
    loadVec(16'h0400);
    loadWord(16'h0270, 32'hA5A5_A5A5);
    loadWord(16'h0271, 32'hA5A5_A5A5);
    curBase     = 16'h0400;
    hash_addr   = 16'h0400;
    result_addr = 16'h0270;
    target      = 32'h0000_FFFF;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("abortDone", 32'(done), 32'd1);
    checkOutput("abortWe", 32'(mif.mem_we), 32'd0);
    checkOutput("abortAddr", 32'(mif.mem_addr), 32'd0);
    checkOutput("abortFound", 32'(found), 32'd0);
    checkOutput("abortMin", min_hash, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abortMem0", memArr[16'h0270], 32'hA5A5_A5A5);
    checkOutput("abortMem1", memArr[16'h0271], 32'hA5A5_A5A5);

    // Full scan after the abort
    applyStimulus(16'h0400, 16'h0270, 32'h0000_FFFF, 1'b1, 8'd11,
                  32'h0000_0ABC, 32'h8000_000B, 1'b0);
    checkOutput("postAbortMem0", memArr[16'h0270], 32'h8000_000B);

    checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
